// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding and
// the request record that carries either a fetch or a data access to the bus.
package mem_port_arbiter_pkg;

   // Widest address/data the request record can carry; the arbiter's
   // ADDR_W/DATA_W parameters must not exceed these.
   localparam int PKG_ADDR_W = 32;
   localparam int PKG_DATA_W = 32;
   localparam int PKG_BE_W   = PKG_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF   = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_e;

   typedef struct packed {
      logic                  we;
      logic [PKG_BE_W-1:0]   be;
      logic [PKG_ADDR_W-1:0] addr;
      logic [PKG_DATA_W-1:0] wdata;
   } mem_req_t;

   // A fetch is always a full-width read.
   function automatic mem_req_t fetch_req(input logic [PKG_ADDR_W-1:0] addr);
      mem_req_t req;
      req       = '0;
      req.be    = '1;
      req.addr  = addr;
      return req;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating counter of consecutive data grants made while a fetch waits.
// Clear wins over increment; at_limit tells the arbiter to favour fetch.
module arb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   logic [CW-1:0] r_cnt;

   // Count data grants that bypass a waiting fetch, saturating at LIMIT.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign at_limit_o = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and data access.
// One transaction in flight; data has priority, but a fetch waiting behind
// STARVE_LIMIT consecutive data grants is served next. Fetches killed by a
// flush still drain their bus response, which is then dropped.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_rvalid_o,
   output logic                if_stall_o,
   input  logic                flush_i,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                d_rvalid_o,
   output logic                d_stall_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [DATA_W/8-1:0] bus_be_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [DATA_W-1:0]   bus_rdata_i
);

   import mem_port_arbiter_pkg::*;

   localparam int BE_W = DATA_W / 8;

   arb_state_e r_state;
   arb_state_e w_state_next;
   arb_owner_e r_owner;
   arb_owner_e w_grant_owner;
   mem_req_t   r_req;
   mem_req_t   w_req_sel;
   logic       r_bus_req;
   logic       r_kill;
   logic       w_grant;
   logic       w_if_cand;
   logic       w_at_limit;
   logic       w_starve_inc;
   logic       w_starve_clr;
   logic       w_resp;
   logic       w_if_rvalid;
   logic       w_d_rvalid;

   // Choose the next owner in IDLE; a fetch flushed in the same cycle is not a candidate.
   always_comb begin
      w_if_cand     = if_req_i & ~flush_i;
      w_grant       = 1'b0;
      w_grant_owner = OWN_IF;
      if (r_state == IDLE) begin
         if (d_req_i && !(w_if_cand && w_at_limit)) begin
            w_grant       = 1'b1;
            w_grant_owner = OWN_DATA;
         end else if (w_if_cand) begin
            w_grant       = 1'b1;
            w_grant_owner = OWN_IF;
         end
      end
   end

   // Mux the winning requester's fields into one request record.
   always_comb begin
      w_req_sel = '0;
      if (w_grant_owner == OWN_DATA) begin
         w_req_sel.we    = d_we_i;
         w_req_sel.be    = PKG_BE_W'(d_be_i);
         w_req_sel.addr  = PKG_ADDR_W'(d_addr_i);
         w_req_sel.wdata = PKG_DATA_W'(d_wdata_i);
      end else begin
         w_req_sel = fetch_req(PKG_ADDR_W'(if_addr_i));
      end
   end

   assign w_starve_inc = w_grant & (w_grant_owner == OWN_DATA) & if_req_i;
   assign w_starve_clr = (w_grant & (w_grant_owner == OWN_IF)) | ~if_req_i;

   arb_starve_ctr #(
      .LIMIT      (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (w_starve_inc),
      .clr_i      (w_starve_clr),
      .at_limit_o (w_at_limit)
   );

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state: issue on grant, wait for bus accept, then for the response.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_grant)      w_state_next = ISSUE;
         ISSUE:   if (bus_gnt_i)    w_state_next = WAIT;
         WAIT:    if (bus_rvalid_i) w_state_next = IDLE;
         default:                   w_state_next = IDLE;
      endcase
   end

   // Latch owner and request fields on grant; hold bus_req until the bus accepts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_owner   <= OWN_IF;
         r_req     <= '0;
         r_bus_req <= 1'b0;
      end else if (w_grant) begin
         r_owner   <= w_grant_owner;
         r_req     <= w_req_sel;
         r_bus_req <= 1'b1;
      end else if ((r_state == ISSUE) && bus_gnt_i) begin
         r_bus_req <= 1'b0;
      end
   end

   // Remember a flush that hit an in-flight fetch so its response is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i || (r_state == IDLE)) begin
         r_kill <= 1'b0;
      end else if (flush_i && (r_owner == OWN_IF)) begin
         r_kill <= 1'b1;
      end
   end

   // FSM outputs: route the bus response to its owner and derive the stalls.
   always_comb begin
      w_resp      = (r_state == WAIT) & bus_rvalid_i;
      w_if_rvalid = w_resp & (r_owner == OWN_IF) & ~r_kill & ~flush_i;
      w_d_rvalid  = w_resp & (r_owner == OWN_DATA);
      if_rvalid_o = w_if_rvalid;
      d_rvalid_o  = w_d_rvalid;
      if_rdata_o  = w_if_rvalid ? bus_rdata_i : '0;
      d_rdata_o   = w_d_rvalid ? bus_rdata_i : '0;
      if_stall_o  = if_req_i & ~w_if_rvalid;
      d_stall_o   = d_req_i & ~w_d_rvalid;
   end

   assign bus_req_o   = r_bus_req;
   assign bus_we_o    = r_req.we;
   assign bus_be_o    = r_req.be[BE_W-1:0];
   assign bus_addr_o  = r_req.addr[ADDR_W-1:0];
   assign bus_wdata_o = r_req.wdata[DATA_W-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_rvalid_o;
   logic        if_stall_o;
   logic        flush_i;
   logic        d_req_i;
   logic        d_we_i;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_rvalid_o;
   logic        d_stall_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_rdata_o   (if_rdata_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_stall_o   (if_stall_o),
      .flush_i      (flush_i),
      .d_req_i      (d_req_i),
      .d_we_i       (d_we_i),
      .d_be_i       (d_be_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_rdata_o    (d_rdata_o),
      .d_rvalid_o   (d_rvalid_o),
      .d_stall_o    (d_stall_o),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_be_o     (bus_be_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (inputs are driven here).
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Wait (bounded) until the bus request is up; returns mid-cycle in ISSUE.
   task automatic wait_issue(input string tag, output logic seen);
      int k;
      k = 0;
      #1;
      while (!bus_req_o && k < 20) begin
         tick();
         #1;
         k++;
      end
      seen = bus_req_o;
      chk({tag, "/req_seen"}, bus_req_o, 1);
   endtask

   // Serve one bus transaction: hold grant low gdly cycles, then grant and
   // respond next cycle; checks fields, stalls and response routing.
   task automatic run_bus(input string tag, input int gdly, input logic [31:0] rd,
                          input logic exp_d, input logic exp_we, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wd);
      logic seen;
      wait_issue(tag, seen);
      if (!seen) return;
      for (int i = 0; i <= gdly; i++) begin
         if (i > 0) begin
            tick();
            #1;
         end
         chk({tag, "/bus_req"}, bus_req_o, 1);
         chk({tag, "/bus_we"}, bus_we_o, exp_we);
         chk({tag, "/bus_be"}, bus_be_o, exp_be);
         chk({tag, "/bus_addr"}, bus_addr_o, exp_addr);
         chk({tag, "/bus_wdata"}, bus_wdata_o, exp_wd);
         chk({tag, "/owner_stall"}, exp_d ? d_stall_o : if_stall_o, 1);
      end
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rd;
      #1;
      chk({tag, "/d_rvalid"}, d_rvalid_o, exp_d);
      chk({tag, "/if_rvalid"}, if_rvalid_o, !exp_d);
      chk({tag, "/rdata"}, exp_d ? d_rdata_o : if_rdata_o, rd);
      chk({tag, "/owner_stall_rsp"}, exp_d ? d_stall_o : if_stall_o, 0);
      $display("txn %s: owner=%s we=%0d be=%h addr=%h rdata=%h", tag,
               exp_d ? "DATA" : "IF", bus_we_o, bus_be_o, bus_addr_o, rd);
      tick();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst_i = 1'b1; if_req_i = 0; if_addr_i = 0; flush_i = 0;
      d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
      bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
      repeat (3) tick();
      rst_i = 1'b0;
      #1;
      chk("rst/bus_req", bus_req_o, 0);
      chk("rst/bus_addr", bus_addr_o, 0);
      chk("rst/bus_be", bus_be_o, 0);
      chk("rst/if_rvalid", if_rvalid_o, 0);
      chk("rst/d_stall", d_stall_o, 0);
      $display("txn reset: outputs idle");

      // Lone fetch with exact cycle timing.
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h100;
      #1;
      chk("fetch/stall_N", if_stall_o, 1);
      chk("fetch/req_N", bus_req_o, 0);
      tick();
      #1;
      chk("fetch/req_N1", bus_req_o, 1);
      chk("fetch/addr_N1", bus_addr_o, 32'h100);
      chk("fetch/stall_N1", if_stall_o, 1);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
      #1;
      chk("fetch/rvalid_N2", if_rvalid_o, 1);
      chk("fetch/rdata_N2", if_rdata_o, 32'hDEADBEEF);
      chk("fetch/stall_N2", if_stall_o, 0);
      chk("fetch/d_rvalid_N2", d_rvalid_o, 0);
      tick();
      bus_rvalid_i = 1'b0; bus_rdata_i = '0; if_req_i = 1'b0;
      #1;
      chk("fetch/rvalid_N3", if_rvalid_o, 0);
      chk("fetch/req_N3", bus_req_o, 0);
      $display("txn lone_fetch: addr=00000100 rdata=deadbeef");

      // Simultaneous fetch and data write: data first, then fetch.
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h300;
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'hF; d_addr_i = 32'h40; d_wdata_i = 32'h12345678;
      run_bus("both_d", 0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678);
      d_req_i = 1'b0; d_we_i = 1'b0;
      run_bus("both_if", 0, 32'hA0A0A0A0, 1'b0, 1'b0, 4'hF, 32'h300, 32'h0);
      if_req_i = 1'b0;

      // Starvation: both held; expect D D D D I D.
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h400;
      d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h80; d_wdata_i = 32'h0;
      for (int i = 0; i < 6; i++) begin
         logic is_d;
         is_d = (i != 4);
         run_bus($sformatf("starve%0d", i), 0, 32'h1000 + i, is_d, 1'b0, 4'hF,
                 is_d ? 32'h80 : 32'h400, 32'h0);
      end
      if_req_i = 1'b0; d_req_i = 1'b0;

      // Flush during WAIT of a fetch, then refetch at 0x200.
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h180;
      wait_issue("flush", seen);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0; flush_i = 1'b1;
      #1;
      chk("flush/rvalid_wait", if_rvalid_o, 0);
      tick();
      flush_i = 1'b0; if_addr_i = 32'h200; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0BAD0;
      #1;
      chk("flush/rvalid_killed", if_rvalid_o, 0);
      chk("flush/rdata_killed", if_rdata_o, 0);
      chk("flush/stall_killed", if_stall_o, 1);
      $display("txn flush_kill: addr=00000180 response dropped");
      tick();
      bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      run_bus("refetch", 0, 32'hCAFEF00D, 1'b0, 1'b0, 4'hF, 32'h200, 32'h0);
      if_req_i = 1'b0;

      // Flush on the same cycle as the fetch response.
      tick();
      if_req_i = 1'b1; if_addr_i = 32'h2C0;
      wait_issue("flush_rsp", seen);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0; flush_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555AAAA;
      #1;
      chk("flush_rsp/rvalid", if_rvalid_o, 0);
      $display("txn flush_on_rsp: addr=000002c0 response dropped");
      tick();
      flush_i = 1'b0; bus_rvalid_i = 1'b0; if_req_i = 1'b0;

      // Fetch and flush together in IDLE: nothing issued.
      tick();
      if_req_i = 1'b1; flush_i = 1'b1; if_addr_i = 32'h280;
      tick();
      flush_i = 1'b0; if_req_i = 1'b0;
      #1;
      chk("flush_idle/no_req", bus_req_o, 0);
      $display("txn flush_idle: no fetch issued");

      // Delayed grant on a partial data write.
      tick();
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h3; d_addr_i = 32'h60; d_wdata_i = 32'hA5A50000;
      run_bus("slow_gnt", 5, 32'h0, 1'b1, 1'b1, 4'h3, 32'h60, 32'hA5A50000);
      d_req_i = 1'b0; d_we_i = 1'b0;

      // Reset while waiting for a data response, then a stray response.
      tick();
      d_req_i = 1'b1; d_be_i = 4'hF; d_addr_i = 32'h44; d_wdata_i = 32'h11;
      wait_issue("rst_wait", seen);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0; rst_i = 1'b1;
      tick();
      rst_i = 1'b0; d_req_i = 1'b0;
      #1;
      chk("rst_wait/bus_req", bus_req_o, 0);
      chk("rst_wait/bus_addr", bus_addr_o, 0);
      chk("rst_wait/bus_be", bus_be_o, 0);
      chk("rst_wait/bus_wdata", bus_wdata_o, 0);
      chk("rst_wait/d_stall", d_stall_o, 0);
      tick();
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77;
      #1;
      chk("rst_wait/stray_d_rvalid", d_rvalid_o, 0);
      chk("rst_wait/stray_if_rvalid", if_rvalid_o, 0);
      chk("rst_wait/stray_d_rdata", d_rdata_o, 0);
      $display("txn reset_in_wait: stray response ignored");
      tick();
      bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
